enc_16x4_pend: RTL and testbench
================================

Name: enc_16x4_pend

Overview:
- Pending-event priority encoder, the inverse of the team's 4-to-16 one-hot decoder.
- Captures up to 16 event lines into a sticky pending register.
- Presents the index of the highest-priority pending event as a 4-bit code on a valid/ready interface.
- Clears each event when the consumer accepts its index. Sits between event sources and an index-consuming sequencer.

Parameters:
N_IN, 16, number of event lines (fixed at 16 for this revision)
W_IDX, 4, index width, equal to clog2(N_IN)

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
en  input  1  capture enable; when low, evt is ignored and pending events still drain
evt  input  16  event request lines, sampled every clock
idx_vld  output  1  idx holds a valid pending event index
idx_rdy  input  1  consumer accepts idx this cycle when idx_vld is high
idx  output  4  encoded index of the presented event
busy  output  1  OR of the pending register
ovf  output  1  sticky; an event arrived on a line already pending
ovf_clr  input  1  clears ovf

Behaviour:
- Reset (rstn low, asynchronous): pend=0, idx_vld=0, idx=0, ovf=0; round-robin pointer=0 when that feature is compiled in.
- ack = idx_vld & idx_rdy. ack_mask = one-hot of idx when ack is high, otherwise 0.
- Pending update: pend <= (pend & ~ack_mask) | (en ? evt : 0).
  - If a bit is acked and re-asserted in the same cycle, the set wins and the bit stays pending.
- Output register load: loads when !idx_vld or ack.
  - cand = pend & ~ack_mask (registered pend, before this edge's new events).
  - cand != 0: idx_vld<=1 and idx<=encode(cand).
  - cand == 0: idx_vld<=0; idx holds its old value.
- Hold rule: while idx_vld=1 and idx_rdy=0, idx and idx_vld stay stable. A newly arrived higher-priority event does not preempt the presented index.
- Default priority: fixed, lowest index wins (bit 0 highest).
- Latency:
  - evt high at edge E0 sets pend after E0; idx_vld rises after E1 if the output is free. Two cycles total.
  - With idx_rdy tied high, back-to-back pending events are presented one per cycle.
- busy = |pend, combinational from the register. The presented bit remains in pend until acked.
- ovf: set at an edge when en & evt[i] & pend[i] & ~ack_mask[i] for any i. ovf_clr clears it; if set and clear are simultaneous, set wins.
- Boundary cases:
  - All 16 pending: 16 successive acks drain in order 0..15.
  - evt held high continuously on a line re-pends it after every ack and sets ovf each cycle that line stays pending un-acked.
  - en low mid-stream: no new captures; the current idx and remaining pend drain normally.

Optional Feature:
- Macro ENC_ROUND_ROBIN_EN.
- Defined:
  - A 4-bit pointer rr_ptr is updated on ack to idx+1 (mod 16).
  - encode() searches cand starting at rr_ptr, ascending and wrapping; the first set bit wins.
  - Reset value of rr_ptr is 0.
- Undefined: fixed lowest-index priority; no pointer register.

Decomposition:
- Package enc_pkg holds:
  - N_IN and W_IDX constants
  - function onehot16(idx) returning 16-bit
  - typedef idx_t (4-bit) and vec_t (16-bit)
- Sub-module prio_enc16: purely combinational.
  - Inputs: vec[15:0], start[3:0] (tied 0 without round-robin).
  - Outputs: found, idx[3:0].
  - Instantiated once for cand.

Test Plan:
1. Reset then evt=16'h0000 for 10 cycles -> idx_vld=0, busy=0, ovf=0 throughout.
2. en=1, evt=16'h0024 pulsed one cycle, idx_rdy=1 -> idx=2 with vld 2 cycles after pulse, idx=5 next cycle, then idx_vld=0, busy=0.
3. idx_rdy=0, pend holds bit 9; pulse evt bit 3 -> idx stays 9 and vld stays high. Release idx_rdy -> 9 acked, then idx=3.
4. evt bit 7 pulsed twice 3 cycles apart with idx_rdy=0 -> ovf=1. Pulse ovf_clr -> ovf=0. Pulse ovf_clr while re-triggering bit 7 -> ovf stays 1.
5. evt=16'hFFFF one cycle, idx_rdy=1 -> idx sequence 0..15 on consecutive cycles. With ENC_ROUND_ROBIN_EN and rr_ptr=10 after a prior ack of 9 -> sequence 10..15, 0..9.
6. rstn dropped asynchronously mid-drain (pend=16'h00F0, idx_vld=1) -> all outputs 0 immediately. After release with evt=0 -> idx_vld stays 0.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared constants, types and helpers for the 16-line pending-event priority encoder.
package enc_pkg;

  localparam int unsigned N_IN  = 16;
  localparam int unsigned W_IDX = 4;

  typedef logic [W_IDX-1:0] idx_t;
  typedef logic [N_IN-1:0]  vec_t;

  function automatic vec_t onehot16(input idx_t i);
    return vec_t'(1) << i;
  endfunction

endpackage

// File: rtl/prio_enc16.sv
// Combinational 16-bit priority search starting at 'start', ascending with wrap;
// with start tied to 0 this is plain lowest-index-wins.
module prio_enc16
  import enc_pkg::*;
(
  input  logic [15:0] vec,
  input  logic [3:0]  start,
  output logic        found,
  output logic [3:0]  idx
);

  vec_t rot;
  idx_t off;

  // Rotate so that bit 'start' lands at position 0, then pick the lowest set bit.
  always_comb begin
    rot = '0;
    off = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      rot[i] = vec[idx_t'(idx_t'(i) + start)];
    end
    for (int i = int'(N_IN) - 1; i >= 0; i--) begin
      if (rot[i]) off = idx_t'(i);
    end
  end

  assign found = |vec;
  assign idx   = idx_t'(start + off);

endmodule

// File: rtl/enc_16x4_pend.sv
// Sticky pending-event register with valid/ready index presentation.
// Optional round-robin arbitration is enabled by defining ENC_ROUND_ROBIN_EN.
module enc_16x4_pend
  import enc_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic [15:0] evt,
  output logic        idx_vld,
  input  logic        idx_rdy,
  output logic [3:0]  idx,
  output logic        busy,
  output logic        ovf,
  input  logic        ovf_clr
);

  vec_t pend_q, pend_d;
  vec_t ack_mask, cand, evt_in;
  logic vld_q, vld_d;
  logic ovf_q, ovf_d;
  idx_t idx_q, idx_d;
  idx_t start, enc_idx;
  logic found, ack, load;

  assign ack      = vld_q & idx_rdy;
  assign ack_mask = ack ? onehot16(idx_q) : '0;
  assign cand     = pend_q & ~ack_mask;
  assign evt_in   = en ? evt : '0;
  assign load     = ~vld_q | ack;

`ifdef ENC_ROUND_ROBIN_EN
  idx_t rr_ptr_q, rr_ptr_d;

  assign start = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (ack) rr_ptr_d = idx_t'(idx_q + idx_t'(1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`else
  assign start = '0;
`endif

  prio_enc16 u_prio (
    .vec   (cand),
    .start (start),
    .found (found),
    .idx   (enc_idx)
  );

  // Next state: set beats ack-clear on pend, set beats clear on ovf.
  always_comb begin
    pend_d = cand | evt_in;
    vld_d  = vld_q;
    idx_d  = idx_q;
    ovf_d  = (|(evt_in & cand)) | (ovf_q & ~ovf_clr);
    if (load) begin
      vld_d = found;
      if (found) idx_d = enc_idx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q <= '0;
      vld_q  <= 1'b0;
      idx_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      vld_q  <= vld_d;
      idx_q  <= idx_d;
      ovf_q  <= ovf_d;
    end
  end

  assign idx_vld = vld_q;
  assign idx     = idx_q;
  assign busy    = |pend_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_enc_16x4_pend.sv
// Directed bench for enc_16x4_pend (default fixed-priority build).
module tb_enc_16x4_pend;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [15:0] evt;
  logic        idx_vld;
  logic        idx_rdy;
  logic [3:0]  idx;
  logic        busy;
  logic        ovf;
  logic        ovf_clr;

  int n_run;
  int n_fail;

  enc_16x4_pend dut (
    .clk     (clk),
    .rstn    (rstn),
    .en      (en),
    .evt     (evt),
    .idx_vld (idx_vld),
    .idx_rdy (idx_rdy),
    .idx     (idx),
    .busy    (busy),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_run++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_run   = 0;
    n_fail  = 0;
    rstn    = 1'b0;
    en      = 1'b0;
    evt     = 16'h0;
    idx_rdy = 1'b0;
    ovf_clr = 1'b0;
    #2;
    check("rst_vld", 16'(idx_vld), 16'h0);
    check("rst_idx", 16'(idx), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_ovf", 16'(ovf), 16'h0);
    step();
    rstn = 1'b1;

    // 1: idle
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_vld", 16'(idx_vld), 16'h0);
      check("idle_busy", 16'(busy), 16'h0);
      check("idle_ovf", 16'(ovf), 16'h0);
    end

    // 2: two events, consumer always ready
    idx_rdy = 1'b1;
    evt = 16'h0024;
    step();
    evt = 16'h0;
    check("t2_vld_e0", 16'(idx_vld), 16'h0);
    check("t2_busy_e0", 16'(busy), 16'h1);
    step();
    check("t2_vld_2", 16'(idx_vld), 16'h1);
    check("t2_idx_2", 16'(idx), 16'h2);
    step();
    check("t2_vld_5", 16'(idx_vld), 16'h1);
    check("t2_idx_5", 16'(idx), 16'h5);
    step();
    check("t2_vld_end", 16'(idx_vld), 16'h0);
    check("t2_busy_end", 16'(busy), 16'h0);
    check("t2_ovf", 16'(ovf), 16'h0);

    // 3: hold rule, no preemption by higher priority
    idx_rdy = 1'b0;
    evt = 16'h0200;
    step();
    evt = 16'h0;
    step();
    check("t3_idx_9", 16'(idx), 16'h9);
    check("t3_vld_9", 16'(idx_vld), 16'h1);
    evt = 16'h0008;
    step();
    evt = 16'h0;
    check("t3_hold_idx", 16'(idx), 16'h9);
    check("t3_hold_vld", 16'(idx_vld), 16'h1);
    step();
    check("t3_hold_idx2", 16'(idx), 16'h9);
    idx_rdy = 1'b1;
    step();
    check("t3_idx_3", 16'(idx), 16'h3);
    check("t3_vld_3", 16'(idx_vld), 16'h1);
    step();
    check("t3_vld_end", 16'(idx_vld), 16'h0);
    check("t3_busy_end", 16'(busy), 16'h0);

    // 4: overflow set, clear, and set-wins-over-clear
    idx_rdy = 1'b0;
    evt = 16'h0080;
    step();
    evt = 16'h0;
    check("t4_ovf_first", 16'(ovf), 16'h0);
    step();
    check("t4_idx_7", 16'(idx), 16'h7);
    step();
    evt = 16'h0080;
    step();
    evt = 16'h0;
    check("t4_ovf_set", 16'(ovf), 16'h1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("t4_ovf_clr", 16'(ovf), 16'h0);
    ovf_clr = 1'b1;
    evt = 16'h0080;
    step();
    ovf_clr = 1'b0;
    evt = 16'h0;
    check("t4_ovf_setwins", 16'(ovf), 16'h1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("t4_ovf_clr2", 16'(ovf), 16'h0);
    idx_rdy = 1'b1;
    step();
    check("t4_vld_end", 16'(idx_vld), 16'h0);
    check("t4_busy_end", 16'(busy), 16'h0);

    // en low: events ignored
    en = 1'b0;
    evt = 16'h0001;
    step();
    step();
    evt = 16'h0;
    check("en_lo_vld", 16'(idx_vld), 16'h0);
    check("en_lo_busy", 16'(busy), 16'h0);
    en = 1'b1;

    // 5: all 16 pending drain in order 0..15
    evt = 16'hFFFF;
    step();
    evt = 16'h0;
    check("t5_vld_e0", 16'(idx_vld), 16'h0);
    for (int i = 0; i < 16; i++) begin
      step();
      check("t5_vld", 16'(idx_vld), 16'h1);
      check("t5_idx", 16'(idx), 16'(i));
    end
    check("t5_busy_last", 16'(busy), 16'h1);
    step();
    check("t5_vld_end", 16'(idx_vld), 16'h0);
    check("t5_busy_end", 16'(busy), 16'h0);

    // 6: asynchronous reset mid-drain
    idx_rdy = 1'b0;
    evt = 16'h00F0;
    step();
    evt = 16'h0;
    step();
    check("t6_idx_4", 16'(idx), 16'h4);
    check("t6_busy", 16'(busy), 16'h1);
    #2;
    rstn = 1'b0;
    #1;
    check("t6_rst_vld", 16'(idx_vld), 16'h0);
    check("t6_rst_idx", 16'(idx), 16'h0);
    check("t6_rst_busy", 16'(busy), 16'h0);
    check("t6_rst_ovf", 16'(ovf), 16'h0);
    step();
    rstn = 1'b1;
    idx_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_post_vld", 16'(idx_vld), 16'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
